// File: rtl/mux_scan_ctrl_if.sv
// Scan-controller bus: scan request/config in, mux select and sample handshake out.
// master = consumer/driver side, slave = mux_scan_ctrl.
interface mux_scan_ctrl_if #(
    parameter int DWELL_W = 4
);
    logic               start;
    logic [3:0]         chan_mask;
    logic [DWELL_W-1:0] dwell;
    logic               y;
    logic               s1;
    logic               s0;
    logic               busy;
    logic [3:0]         sample;
    logic               sample_valid;
    logic               sample_ready;

    modport master (
        output start, chan_mask, dwell, y, sample_ready,
        input  s1, s0, busy, sample, sample_valid
    );

    modport slave (
        input  start, chan_mask, dwell, y, sample_ready,
        output s1, s0, busy, sample, sample_valid
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps a 4:1 mux over enabled channels, waits dwell cycles per select, captures y per channel.
// Latency: sample_valid rises popcount(mask)*(dwell+2) cycles after the start edge; all outputs registered.
// Backpressure: result held in DONE until sample_ready; MUX_SCAN_CONT_EN restarts the scan on handshake.
module mux_scan_ctrl #(
    parameter int DWELL_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    mux_scan_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [3:0]         mask_q, mask_d;
    logic [3:0]         sample_q, sample_d;
    logic [1:0]         sel_q, sel_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [3:0]         higher;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Enabled channels strictly above the current select; disabled ones cost no cycles.
    assign higher = mask_q & (4'b1110 << sel_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dwell_d  = dwell_q;
        mask_d   = mask_q;
        sample_d = sample_q;
        sel_d    = sel_q;
        case (state_q)
            IDLE: begin
                if (bus.start && (bus.chan_mask != 4'd0)) begin
                    mask_d   = bus.chan_mask;
                    dwell_d  = bus.dwell;
                    sample_d = 4'd0;
                    sel_d    = lowest(bus.chan_mask);
                    cnt_d    = bus.dwell;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) state_d = SAMPLE;
                else             cnt_d   = cnt_q - DWELL_W'(1);
            end
            SAMPLE: begin
                sample_d[sel_q] = bus.y;
                if (|higher) begin
                    sel_d   = lowest(higher);
                    cnt_d   = dwell_q;
                    state_d = SETTLE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.sample_ready) begin
`ifdef MUX_SCAN_CONT_EN
                    sample_d = 4'd0;
                    sel_d    = lowest(mask_q);
                    cnt_d    = dwell_q;
                    state_d  = SETTLE;
`else
                    state_d  = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dwell_q  <= '0;
            mask_q   <= 4'd0;
            sample_q <= 4'd0;
            sel_q    <= 2'd0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dwell_q  <= dwell_d;
            mask_q   <= mask_d;
            sample_q <= sample_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.s1           = sel_q[1];
    assign bus.s0           = sel_q[0];
    assign bus.busy         = busy_q;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: scan-level reference model checked every cycle plus directed literal checks.
module tb_mux_scan_ctrl;

    logic clk;
    logic rst;
    logic [3:0] pat;
    int n_checks;
    int n_fail;
    bit checking;

    mux_scan_ctrl_if #(.DWELL_W(4)) bif ();

    mux_scan_ctrl #(.DWELL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // Bench models the downstream mux inputs i3..i0 = pat.
    assign bif.y = pat[{bif.s1, bif.s0}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: scan position is just the edge count since acceptance.
    function automatic logic [1:0] nth_chan(input logic [3:0] m, input int j);
        int c;
        c = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                if (c == j) return 2'(i);
                c++;
            end
        end
        return 2'd0;
    endfunction

    function automatic logic [3:0] cap(input logic [3:0] m, input logic [3:0] p, input int j);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < j; i++) r[nth_chan(m, i)] = p[nth_chan(m, i)];
        return r;
    endfunction

    int         m_phase;
    int         m_n;
    logic [3:0] m_mask;
    logic [3:0] m_dwell;
    logic [1:0] m_sel;
    logic [3:0] m_sample;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_n <= 0; m_mask <= 4'd0; m_dwell <= 4'd0;
            m_sel <= 2'd0; m_sample <= 4'd0;
        end else begin
            case (m_phase)
                0: if (bif.start && bif.chan_mask != 4'd0) begin
                    m_mask <= bif.chan_mask; m_dwell <= bif.dwell; m_n <= 0;
                    m_phase <= 1; m_sample <= 4'd0; m_sel <= nth_chan(bif.chan_mask, 0);
                end
                1: begin
                    m_n <= m_n + 1;
                    if (m_n + 1 == $countones(m_mask) * (int'(m_dwell) + 2)) begin
                        m_phase  <= 2;
                        m_sample <= cap(m_mask, pat, $countones(m_mask));
                    end else begin
                        m_sel    <= nth_chan(m_mask, (m_n + 1) / (int'(m_dwell) + 2));
                        m_sample <= cap(m_mask, pat, (m_n + 1) / (int'(m_dwell) + 2));
                    end
                end
                default: if (bif.sample_ready) begin
`ifdef MUX_SCAN_CONT_EN
                    m_n <= 0; m_phase <= 1; m_sample <= 4'd0; m_sel <= nth_chan(m_mask, 0);
`else
                    m_phase <= 0;
`endif
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("model_sel", {30'd0, bif.s1, bif.s0}, {30'd0, m_sel});
            chk("model_busy", {31'd0, bif.busy}, {31'd0, m_phase != 0});
            chk("model_valid", {31'd0, bif.sample_valid}, {31'd0, m_phase == 2});
            chk("model_sample", {28'd0, bif.sample}, {28'd0, m_sample});
        end
    end

    task automatic do_start(input logic [3:0] m, input logic [3:0] d, input logic [3:0] p);
        @(negedge clk);
        pat = p; bif.chan_mask = m; bif.dwell = d; bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (bif.sample_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; checking = 1'b0;
        pat = 4'd0; rst = 1'b1;
        bif.start = 1'b0; bif.chan_mask = 4'd0; bif.dwell = 4'd0; bif.sample_ready = 1'b0;
        #12;
        chk("rst_sel", {30'd0, bif.s1, bif.s0}, 32'd0);
        chk("rst_busy", {31'd0, bif.busy}, 32'd0);
        chk("rst_valid", {31'd0, bif.sample_valid}, 32'd0);
        chk("rst_sample", {28'd0, bif.sample}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        checking = 1'b1;

`ifdef MUX_SCAN_CONT_EN
        bif.sample_ready = 1'b1;
        do_start(4'b0010, 4'd1, 4'b0010);
        for (int k = 0; k < 24; k++) begin
            chk("cont_busy", {31'd0, bif.busy}, 32'd1);
            chk("cont_sel", {30'd0, bif.s1, bif.s0}, 32'd1);
            @(negedge clk);
        end
`else
        // Full 4-channel scan, dwell 2: each select held 4 cycles, valid after edge 16.
        bif.sample_ready = 1'b1;
        do_start(4'b1111, 4'd2, 4'b1010);
        for (int k = 1; k <= 16; k++) begin
            chk("s031_sel", {30'd0, bif.s1, bif.s0}, 32'((k - 1) / 4));
            chk("s031_valid_low", {31'd0, bif.sample_valid}, 32'd0);
            @(negedge clk);
        end
        chk("s031_valid", {31'd0, bif.sample_valid}, 32'd1);
        chk("s031_sample", {28'd0, bif.sample}, 32'b1010);
        @(negedge clk);
        chk("s031_idle", {31'd0, bif.busy}, 32'd0);

        // Sparse mask, dwell 0: 00 then 10, two cycles each.
        do_start(4'b0101, 4'd0, 4'b1111);
        for (int k = 1; k <= 4; k++) begin
            chk("s032_sel", {30'd0, bif.s1, bif.s0}, (k <= 2) ? 32'd0 : 32'd2);
            @(negedge clk);
        end
        chk("s032_valid", {31'd0, bif.sample_valid}, 32'd1);
        chk("s032_sample", {28'd0, bif.sample}, 32'b0101);

        // Empty mask is ignored; last select and sample retained.
        do_start(4'b0000, 4'd3, 4'b0000);
        repeat (3) @(negedge clk);
        chk("s033_busy", {31'd0, bif.busy}, 32'd0);
        chk("s033_sample", {28'd0, bif.sample}, 32'b0101);
        chk("s033_sel", {30'd0, bif.s1, bif.s0}, 32'd2);

        // Backpressure: result held 5 cycles, start during hold ignored.
        bif.sample_ready = 1'b0;
        do_start(4'b0110, 4'd1, 4'b0011);
        wait_valid(40, "s034_timeout");
        bif.start = 1'b1; bif.chan_mask = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            chk("s034_hold_valid", {31'd0, bif.sample_valid}, 32'd1);
            chk("s034_hold_sample", {28'd0, bif.sample}, 32'b0010);
            @(negedge clk);
        end
        bif.start = 1'b0; bif.sample_ready = 1'b1;
        @(negedge clk);
        chk("s034_cleared", {31'd0, bif.sample_valid}, 32'd0);
        chk("s034_idle", {31'd0, bif.busy}, 32'd0);
        chk("s034_keep", {28'd0, bif.sample}, 32'b0010);

        // Async reset during channel 2 settle, then a clean scan.
        do_start(4'b1111, 4'd3, 4'b0110);
        repeat (11) @(negedge clk);
        chk("s035_mid_sel", {30'd0, bif.s1, bif.s0}, 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("s035_rst_sel", {30'd0, bif.s1, bif.s0}, 32'd0);
        chk("s035_rst_busy", {31'd0, bif.busy}, 32'd0);
        chk("s035_rst_sample", {28'd0, bif.sample}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("s035_no_valid", {31'd0, bif.sample_valid}, 32'd0);
        do_start(4'b1111, 4'd3, 4'b0110);
        wait_valid(40, "s035_timeout");
        chk("s035_sample", {28'd0, bif.sample}, 32'b0110);
        repeat (3) @(negedge clk);
`endif
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
